// File: rtl/noc_pkg.sv
// Shared types and helpers for the NoC endpoint transmit path.
// Holds the packet-framing state enum and the credit counter width function.
package noc_pkg;

   typedef enum logic {
      HEAD = 1'b0,
      BODY = 1'b1
   } state_t;

   // Width able to hold every value 0..depth inclusive.
   function automatic int credit_width(input int depth);
      return (depth < 1) ? 1 : $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Credit counter for the downstream router input buffer: starts full, saturates
// on a surplus credit and raises a sticky overflow flag.
module noc_credit_counter
   import noc_pkg::*;
#(
   parameter int FLIT_BUFFER_DEPTH = 2,
   localparam int CW = credit_width(FLIT_BUFFER_DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          accept,
   input  logic          credit,
   output logic [CW-1:0] cnt,
   output logic          err_credit_overflow
);

   localparam logic [CW-1:0] FULL = CW'(FLIT_BUFFER_DEPTH);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt                 <= FULL;
         err_credit_overflow <= 1'b0;
      end else if (credit && !accept) begin
         if (cnt == FULL) begin
            err_credit_overflow <= 1'b1;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end else if (accept && !credit) begin
         // The parent only accepts with a non-zero count, so this never wraps.
         cnt <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/noc_endpoint_tx.sv
// NoC endpoint transmitter: credit-gated flit injection with per-packet
// destination lock. Define NOC_TX_PERF_EN to add pkt_count/stall_count outputs.
module noc_endpoint_tx
   import noc_pkg::*;
#(
   parameter int DEST_WIDTH        = 4,
   parameter int FLIT_WIDTH        = 256,
   parameter int FLIT_BUFFER_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [FLIT_WIDTH-1:0] in_data,
   input  logic [DEST_WIDTH-1:0] in_dest,
   input  logic                  in_last,
   output logic [FLIT_WIDTH-1:0] noc_data,
   output logic [DEST_WIDTH-1:0] noc_dest,
   output logic                  noc_is_tail,
   output logic                  noc_send,
   input  logic                  noc_credit,
   output logic                  err_credit_overflow
`ifdef NOC_TX_PERF_EN
   ,
   output logic [31:0]           pkt_count,
   output logic [31:0]           stall_count
`endif
);

   localparam int CW = credit_width(FLIT_BUFFER_DEPTH);

   logic [CW-1:0]         credit_cnt;
   logic                  accept;
   state_t                state;
   logic [DEST_WIDTH-1:0] dest_lock;

   // NOTE: in_ready is decoded straight from the credit register, so it never
   // depends combinationally on in_valid or noc_credit.
   assign in_ready = (credit_cnt != '0);
   assign accept   = in_valid && in_ready;

   noc_credit_counter #(
      .FLIT_BUFFER_DEPTH(FLIT_BUFFER_DEPTH)
   ) u_credit (
      .clk                 (clk),
      .rst_n               (rst_n),
      .accept              (accept),
      .credit              (noc_credit),
      .cnt                 (credit_cnt),
      .err_credit_overflow (err_credit_overflow)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= HEAD;
         dest_lock   <= '0;
         noc_send    <= 1'b0;
         noc_is_tail <= 1'b0;
         noc_data    <= '0;
         noc_dest    <= '0;
      end else begin
         noc_send <= accept;
         if (accept) begin
            noc_data    <= in_data;
            noc_is_tail <= in_last;
            if (state == HEAD) begin
               dest_lock <= in_dest;
               noc_dest  <= in_dest;
               state     <= in_last ? HEAD : BODY;
            end else begin
               // Body flits follow the head's route whatever in_dest says.
               noc_dest <= dest_lock;
               if (in_last) begin
                  state <= HEAD;
               end
            end
         end
      end
   end

`ifdef NOC_TX_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_count   <= '0;
         stall_count <= '0;
      end else begin
         if (accept && in_last) begin
            pkt_count <= pkt_count + 32'd1;
         end
         if (in_valid && !in_ready) begin
            stall_count <= stall_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_noc_endpoint_tx.sv
// Self-checking bench for noc_endpoint_tx: directed vector table, hand-written
// reset/perf sequences and a randomized run against a behavioural model.
module tb_noc_endpoint_tx;

   localparam int DW    = 4;
   localparam int FW    = 256;
   localparam int DEPTH = 2;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [FW-1:0] in_data;
   logic [DW-1:0] in_dest;
   logic          in_last;
   logic [FW-1:0] noc_data;
   logic [DW-1:0] noc_dest;
   logic          noc_is_tail;
   logic          noc_send;
   logic          noc_credit;
   logic          err_credit_overflow;
`ifdef NOC_TX_PERF_EN
   logic [31:0]   pkt_count;
   logic [31:0]   stall_count;
`endif

   noc_endpoint_tx #(
      .DEST_WIDTH        (DW),
      .FLIT_WIDTH        (FW),
      .FLIT_BUFFER_DEPTH (DEPTH)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .in_data             (in_data),
      .in_dest             (in_dest),
      .in_last             (in_last),
      .noc_data            (noc_data),
      .noc_dest            (noc_dest),
      .noc_is_tail         (noc_is_tail),
      .noc_send            (noc_send),
      .noc_credit          (noc_credit),
      .err_credit_overflow (err_credit_overflow)
`ifdef NOC_TX_PERF_EN
      ,
      .pkt_count           (pkt_count),
      .stall_count         (stall_count)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Inputs apply on the falling edge; outputs are sampled on the falling edge
   // that follows the rising edge which consumed them.
   task automatic drive(input logic v, input logic l, input logic [DW-1:0] d,
                        input logic cr, input logic [FW-1:0] data);
      in_valid   = v;
      in_last    = l;
      in_dest    = d;
      noc_credit = cr;
      in_data    = data;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_last    = 1'b0;
      in_dest    = '0;
      noc_credit = 1'b0;
      in_data    = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [FW-1:0] flit_of(input int r);
      logic [FW-1:0] f;
      for (int k = 0; k < FW / 32; k++) f[k*32 +: 32] = 32'(r * 8 + k) ^ 32'hC0DE_0000;
      return f;
   endfunction

   function automatic logic [FW-1:0] rand_flit();
      logic [FW-1:0] f;
      for (int k = 0; k < FW / 32; k++) f[k*32 +: 32] = $urandom;
      return f;
   endfunction

   typedef struct {
      logic          v;
      logic          last;
      logic [DW-1:0] dest;
      logic          cr;
      logic          e_ready;
      logic          e_send;
      logic [DW-1:0] e_dest;
      logic          e_tail;
      logic          e_err;
   } vec_t;

   vec_t tbl[16];

   // Behavioural model state for the random phase.
   int            m_credits;
   bit            m_in_packet;
   logic [DW-1:0] m_route;
   logic          m_send, m_tail, m_err;
   logic [DW-1:0] m_dest;
   logic [FW-1:0] m_data;
   int unsigned   m_pkt, m_stall;

   initial begin
      logic [FW-1:0] last_data;
      logic          v, l, cr, acc;
      logic [DW-1:0] d;
      logic [FW-1:0] data;

      // Each row: inputs for this cycle, then outputs expected before its edge.
      // Rows 0-6: drain with no credits, stall, one credit releases flit 3.
      tbl[0]  = '{1'b1, 1'b0, 4'd3, 1'b0,  1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 4'd3, 1'b0,  1'b1, 1'b1, 4'd3, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 4'd3, 1'b0,  1'b0, 1'b1, 4'd3, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 1'b1, 4'd3, 1'b1,  1'b0, 1'b0, 4'd3, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b1, 4'd7, 1'b0,  1'b1, 1'b0, 4'd3, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 4'd0, 1'b1,  1'b0, 1'b1, 4'd3, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 4'd0, 1'b1,  1'b1, 1'b0, 4'd3, 1'b1, 1'b0};
      // Rows 7-11: 3-flit packet 5,9,9 with accept+credit at cnt 1, then overflow.
      tbl[7]  = '{1'b1, 1'b0, 4'd5, 1'b0,  1'b1, 1'b0, 4'd3, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 4'd9, 1'b1,  1'b1, 1'b1, 4'd5, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 1'b1, 4'd9, 1'b1,  1'b1, 1'b1, 4'd5, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 4'd0, 1'b1,  1'b1, 1'b1, 4'd5, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 4'd0, 1'b1,  1'b1, 1'b0, 4'd5, 1'b1, 1'b0};
      // Rows 12-15: counter saturated at 2, exactly two more flits fit.
      tbl[12] = '{1'b1, 1'b0, 4'd2, 1'b0,  1'b1, 1'b0, 4'd5, 1'b1, 1'b1};
      tbl[13] = '{1'b1, 1'b1, 4'd4, 1'b0,  1'b1, 1'b1, 4'd2, 1'b0, 1'b1};
      tbl[14] = '{1'b0, 1'b0, 4'd0, 1'b0,  1'b0, 1'b1, 4'd2, 1'b1, 1'b1};
      tbl[15] = '{1'b0, 1'b0, 4'd0, 1'b0,  1'b0, 1'b0, 4'd2, 1'b1, 1'b1};

      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_last    = 1'b0;
      in_dest    = '0;
      noc_credit = 1'b0;
      in_data    = '0;
      repeat (2) @(negedge clk);
      check("rst_send",  {255'd0, noc_send},    256'd0);
      check("rst_tail",  {255'd0, noc_is_tail}, 256'd0);
      check("rst_data",  noc_data,              256'd0);
      check("rst_dest",  256'(noc_dest),        256'd0);
      check("rst_err",   {255'd0, err_credit_overflow}, 256'd0);
      rst_n = 1'b1;

      last_data = '0;
      for (int r = 0; r < 16; r++) begin
         if (tbl[r].e_send) last_data = flit_of(r - 1);
         check($sformatf("tbl%0d_ready", r), {255'd0, in_ready},    {255'd0, tbl[r].e_ready});
         check($sformatf("tbl%0d_send",  r), {255'd0, noc_send},    {255'd0, tbl[r].e_send});
         check($sformatf("tbl%0d_dest",  r), 256'(noc_dest),        256'(tbl[r].e_dest));
         check($sformatf("tbl%0d_tail",  r), {255'd0, noc_is_tail}, {255'd0, tbl[r].e_tail});
         check($sformatf("tbl%0d_err",   r), {255'd0, err_credit_overflow}, {255'd0, tbl[r].e_err});
         check($sformatf("tbl%0d_data",  r), noc_data,              last_data);
         drive(tbl[r].v, tbl[r].last, tbl[r].dest, tbl[r].cr, flit_of(r));
      end

      // Reset asserted while a packet is in BODY.
      drive(1'b0, 1'b0, 4'd0, 1'b1, '0);
      drive(1'b0, 1'b0, 4'd0, 1'b1, '0);
      drive(1'b1, 1'b0, 4'd6, 1'b0, flit_of(40));
      check("mid_head_send", {255'd0, noc_send}, 256'd1);
      check("mid_head_dest", 256'(noc_dest), 256'd6);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("mid_rst_send",  {255'd0, noc_send},    256'd0);
      check("mid_rst_tail",  {255'd0, noc_is_tail}, 256'd0);
      check("mid_rst_data",  noc_data,              256'd0);
      check("mid_rst_dest",  256'(noc_dest),        256'd0);
      check("mid_rst_err",   {255'd0, err_credit_overflow}, 256'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check("mid_rel_ready", {255'd0, in_ready}, 256'd1);
      drive(1'b1, 1'b0, 4'd11, 1'b0, flit_of(41));
      check("mid_new_send", {255'd0, noc_send}, 256'd1);
      check("mid_new_dest", 256'(noc_dest), 256'd11);
      drive(1'b1, 1'b1, 4'd12, 1'b0, flit_of(42));
      check("mid_body_dest", 256'(noc_dest), 256'd11);
      check("mid_body_tail", {255'd0, noc_is_tail}, 256'd1);
      check("mid_body_data", noc_data, flit_of(42));

      // Randomized run against the behavioural model.
      do_reset();
      m_credits = DEPTH; m_in_packet = 0; m_route = '0;
      m_send = 0; m_tail = 0; m_err = 0; m_dest = '0; m_data = '0;
      m_pkt = 0; m_stall = 0;
      for (int c = 0; c < 3000; c++) begin
         check("rnd_ready", {255'd0, in_ready},    {255'd0, m_credits != 0});
         check("rnd_send",  {255'd0, noc_send},    {255'd0, m_send});
         check("rnd_dest",  256'(noc_dest),        256'(m_dest));
         check("rnd_tail",  {255'd0, noc_is_tail}, {255'd0, m_tail});
         check("rnd_data",  noc_data,              m_data);
         check("rnd_err",   {255'd0, err_credit_overflow}, {255'd0, m_err});
`ifdef NOC_TX_PERF_EN
         check("rnd_pkt",   256'(pkt_count),   256'(m_pkt));
         check("rnd_stall", 256'(stall_count), 256'(m_stall));
`endif
         v    = ($urandom_range(0, 3) != 0);
         l    = ($urandom_range(0, 2) == 0);
         d    = DW'($urandom);
         cr   = ($urandom_range(0, 1) == 1);
         data = rand_flit();

         acc = v && (m_credits > 0);
         if (v && m_credits == 0) m_stall++;
         m_send = acc;
         if (acc) begin
            m_data = data;
            m_tail = l;
            if (!m_in_packet) m_route = d;
            m_dest = m_route;
            m_in_packet = !l;
            if (l) m_pkt++;
         end
         if (cr && !acc && m_credits == DEPTH) m_err = 1'b1;
         else m_credits = m_credits + int'(cr) - int'(acc);
         drive(v, l, d, cr, data);
      end

`ifdef NOC_TX_PERF_EN
      // Four single-flit packets and three stalled cycles.
      do_reset();
      drive(1'b1, 1'b1, 4'd1, 1'b0, flit_of(50));
      drive(1'b1, 1'b1, 4'd2, 1'b0, flit_of(51));
      drive(1'b1, 1'b1, 4'd3, 1'b0, flit_of(52));
      drive(1'b1, 1'b1, 4'd3, 1'b0, flit_of(52));
      drive(1'b1, 1'b1, 4'd3, 1'b1, flit_of(52));
      drive(1'b1, 1'b1, 4'd3, 1'b1, flit_of(52));
      drive(1'b1, 1'b1, 4'd4, 1'b1, flit_of(53));
      drive(1'b0, 1'b0, 4'd0, 1'b0, '0);
      check("perf_pkt",   256'(pkt_count),   256'd4);
      check("perf_stall", 256'(stall_count), 256'd3);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/noc_endpoint_tx.md
NOC_ENDPOINT_TX -- requirements
Module: noc_endpoint_tx

Interface
REQ-001 SHALL use parameter DEST_WIDTH, default 4, as the destination endpoint ID width.
REQ-002 SHALL use parameter FLIT_WIDTH, default 256, as the flit payload width.
REQ-003 SHALL use parameter FLIT_BUFFER_DEPTH, default 2, as the number of downstream router input-buffer slots, which is also the initial credit count.
REQ-004 SHALL run on one clock and use asynchronous active-low reset: clk input 1 (clock); rst_n input 1 (async active-low reset).
REQ-005 SHALL provide the upstream flit stream ports: in_valid input 1; in_ready output 1; in_data input FLIT_WIDTH; in_dest input DEST_WIDTH; in_last input 1 (last flit of packet).
REQ-006 SHALL provide the NoC-side ports: noc_data output FLIT_WIDTH; noc_dest output DEST_WIDTH; noc_is_tail output 1; noc_send output 1 (flit valid, one cycle per flit); noc_credit input 1 (one slot freed per cycle asserted).
REQ-007 SHALL provide err_credit_overflow output 1, a sticky flag for a credit returned while the counter is full.

Function
REQ-008 SHALL keep credit_cnt, width $clog2(FLIT_BUFFER_DEPTH+1), and drive in_ready = (credit_cnt != 0) combinationally from the register.
REQ-009 SHALL accept a flit when in_valid && in_ready; an accepted flit SHALL appear on noc_send/noc_data/noc_dest/noc_is_tail exactly 1 cycle later, all registered.
REQ-010 SHALL drive noc_send 0 in any cycle after a non-accept cycle; noc_data, noc_dest and noc_is_tail SHALL hold their previous values.
REQ-011 SHALL update credit_cnt each cycle as next = cnt - accept + noc_credit; an accept and a credit in the same cycle SHALL leave it unchanged.
REQ-012 SHALL, on noc_credit while cnt == FLIT_BUFFER_DEPTH with no accept, saturate the counter and set err_credit_overflow, which is cleared only by reset.
REQ-013 SHALL stall with in_ready 0 at cnt == 0 and accept no flit; a credit arriving in that cycle SHALL raise in_ready the following cycle.
REQ-014 SHALL run an FSM with states HEAD and BODY; the reset state is HEAD.
REQ-015 SHALL, on accept in HEAD, latch in_dest into dest_lock; with in_last 0 it SHALL go to BODY, and with in_last 1 (single-flit packet) it SHALL stay in HEAD.
REQ-016 SHALL, on accept in BODY, drive noc_dest from dest_lock regardless of in_dest; with in_last 1 it SHALL return to HEAD.
REQ-017 SHALL drive noc_is_tail to the registered in_last of the accepted flit.
REQ-018 SHALL sustain a throughput of 1 flit/cycle when credits return every cycle.

Reset
REQ-019 SHALL, on rst_n low and at any time including mid-packet, immediately set: credit_cnt = FLIT_BUFFER_DEPTH; state HEAD; noc_send 0; noc_is_tail 0; noc_data 0; noc_dest 0; dest_lock 0; err_credit_overflow 0.
REQ-020 SHALL drive in_ready 1 in the first cycle after reset release.

Configuration
REQ-021 SHALL, when macro NOC_TX_PERF_EN is defined, add the outputs pkt_count[31:0] (increment per accepted in_last flit) and stall_count[31:0] (increment per cycle with in_valid && !in_ready); both SHALL reset to 0 and wrap at 2^32.
REQ-022 SHALL, without NOC_TX_PERF_EN, have no pkt_count or stall_count ports or registers and otherwise identical behaviour.

Structure
REQ-023 SHALL place the FSM state enum (HEAD, BODY) and a credit-width function in shared package noc_pkg.
REQ-024 SHALL implement the credit counter, with its saturation and overflow flag, as sub-module noc_credit_counter parameterised by FLIT_BUFFER_DEPTH.

Verification
REQ-025 SHALL verify the initial drain: DEPTH=2, no credits, in_valid held with 3 flits -> 2 accepted; in_ready 0 on cycle 3; noc_send high on cycles 2 and 3 only.
REQ-026 SHALL verify credit return: after the drain, one noc_credit pulse -> in_ready 1 next cycle; third flit on noc_send 1 cycle after its accept.
REQ-027 SHALL verify dest lock: a 3-flit packet with in_dest 5,9,9 and in_last on flit 3 -> noc_dest = 5 on all three; noc_is_tail on the third only.
REQ-028 SHALL verify simultaneous events: accept and noc_credit in the same cycle at cnt=1 -> cnt stays 1; an extra credit at cnt=2 -> err_credit_overflow 1 and cnt 2.
REQ-029 SHALL verify reset mid-operation: rst_n low mid-packet in BODY -> noc_send 0, in_ready 1 after release, next flit treated as HEAD with its own in_dest.
REQ-030 SHALL verify the counters with NOC_TX_PERF_EN: 4 single-flit packets plus 3 stall cycles -> pkt_count 4, stall_count 3.
